// File: rtl/alu_status_reg_if.sv
// Valid/ready stream carrying one ALU result word and its {OF, CF, ZF, BF} flag vector.
// The master drives valid/result/flags; the slave drives ready.
interface alu_status_reg_if #(
  parameter int unsigned BITS = 8
);
  logic            valid;
  logic            ready;
  logic [BITS-1:0] result;
  logic [3:0]      flags;

  modport master (output valid, output result, output flags, input ready);
  modport slave  (input valid, input result, input flags, output ready);
endinterface

// File: rtl/alu_status_reg.sv
// Two-entry skid buffer for ALU result/flag words, with sticky flag bits and a
// saturating counter of accepted words that carry BF.
module alu_status_reg #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  alu_status_reg_if.slave    up,
  alu_status_reg_if.master   dn,
  input  logic               i_clear,
  output logic [3:0]         o_sticky,
  output logic [CNT_W-1:0]   o_bf_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic [BITS-1:0]   head_result_q, head_result_d;
  logic [3:0]        head_flags_q, head_flags_d;
  logic [BITS-1:0]   skid_result_q, skid_result_d;
  logic [3:0]        skid_flags_q, skid_flags_d;
  logic [3:0]        sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              emit;
  logic [CNT_W-1:0]  cnt_base;

  assign accept = up.valid && ready_q;
  assign emit   = valid_q && dn.ready;

  always_comb begin
    state_d       = state_q;
    head_result_d = head_result_q;
    head_flags_d  = head_flags_q;
    skid_result_d = skid_result_q;
    skid_flags_d  = skid_flags_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          head_result_d = up.result;
          head_flags_d  = up.flags;
          state_d       = StOne;
        end
      end
      StOne: begin
        if (accept && emit) begin
          head_result_d = up.result;
          head_flags_d  = up.flags;
        end else if (accept) begin
          skid_result_d = up.result;
          skid_flags_d  = up.flags;
          state_d       = StTwo;
        end else if (emit) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // ready_q is low here, so only an emit can happen
        if (emit) begin
          head_result_d = skid_result_q;
          head_flags_d  = skid_flags_q;
          state_d       = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    valid_d = (state_d != StEmpty);
    ready_d = (state_d != StTwo);
  end

  always_comb begin
    sticky_d = i_clear ? 4'b0000 : sticky_q;
    if (accept) begin
      sticky_d = sticky_d | up.flags;
    end
    cnt_base = i_clear ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (accept && up.flags[0] && (cnt_base != CntMax)) begin
      cnt_d = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StEmpty;
      valid_q       <= 1'b0;
      ready_q       <= 1'b0;
      head_result_q <= '0;
      head_flags_q  <= '0;
      skid_result_q <= '0;
      skid_flags_q  <= '0;
      sticky_q      <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      ready_q       <= ready_d;
      head_result_q <= head_result_d;
      head_flags_q  <= head_flags_d;
      skid_result_q <= skid_result_d;
      skid_flags_q  <= skid_flags_d;
      sticky_q      <= sticky_d;
      cnt_q         <= cnt_d;
    end
  end

  assign up.ready   = ready_q;
  assign dn.valid   = valid_q;
  assign dn.result  = head_result_q;
  assign dn.flags   = head_flags_q;
  assign o_sticky   = sticky_q;
  assign o_bf_count = cnt_q;

endmodule
